ofmap_packer: RTL and testbench
===============================

OFMAP_PACKER -- requirements
Module: ofmap_packer

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 32, bytes per output RAM line (fixed 32 in this revision).
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_we  input  1  byte write strobe from ppu.
REQ-005 SHALL have port i_data  input  8  byte value from ppu.
REQ-006 SHALL have port i_addr  input  13  byte address from ppu; [12:5] line tag, [4:0] byte lane.
REQ-007 SHALL have port i_flush  input  1  one-cycle request to emit any partial line (driven by matrix done).
REQ-008 SHALL have port o_ram_we  output  1  line write strobe to output RAM.
REQ-009 SHALL have port o_ram_addr  output  8  line address.
REQ-010 SHALL have port o_ram_data  output  256  line data; lane k at bits [8k+7:8k].
REQ-011 SHALL have port o_ram_be  output  32  byte enables; bit k enables lane k.
REQ-012 SHALL have port o_flush_done  output  1  one-cycle pulse when flush completes.

Function
REQ-013 SHALL hold a line buffer (256b), valid mask (32b), tag (8b), and a state in {EMPTY, FILL, FLUSH2}.
REQ-014 All outputs SHALL be registered; o_ram_* reflect the input event of the previous cycle (latency 1).
REQ-015 o_ram_we, o_flush_done SHALL be single-cycle pulses; o_ram_addr/data/be SHALL be 0 whenever o_ram_we=0.
REQ-016 Emitted o_ram_data lanes with be=0 SHALL be 0.
REQ-017 EMPTY + i_we: load byte into lane addr[4:0], tag=addr[12:5], mask = that lane only -> FILL.
REQ-018 FILL + i_we, same tag: write lane, set mask bit; rewrite of a set lane overwrites data, mask unchanged.
REQ-019 FILL + i_we, same tag, mask becomes all-ones: emit line (including this byte) next cycle, clear buffer -> EMPTY.
REQ-020 FILL + i_we, different tag: emit old line (be=mask) next cycle; same cycle start new line with incoming byte -> FILL.
REQ-021 i_flush, no i_we: FILL -> emit line, o_flush_done in same cycle as o_ram_we, -> EMPTY; EMPTY -> o_flush_done next cycle, no write.
REQ-022 i_flush + i_we same cycle: byte applied first per REQ-017..020, then flush; if only one line results, emit it with o_flush_done; if REQ-020 applies, emit old line, enter FLUSH2, next cycle emit new line with o_flush_done -> EMPTY.
REQ-023 Full-line completion + i_flush same cycle: single emit with o_flush_done asserted.
REQ-024 In FLUSH2, i_we/i_flush SHALL be ignored (upstream never drives them there; checker flags violation).
REQ-025 At most one line write per cycle; no byte written by ppu SHALL be dropped outside REQ-024/reset.
REQ-026 Line tag wrap 0xFF -> 0x00 treated as an ordinary tag change (no special case).

Reset
REQ-027 i_rst=1 at clock edge SHALL clear buffer, mask, tag to 0, state EMPTY, all outputs 0 on next cycle.
REQ-028 Reset during FILL/FLUSH2 SHALL discard the partial line with no RAM write and no o_flush_done.
REQ-029 Reset SHALL take priority over i_we and i_flush in the same cycle.

Verification
REQ-030 Writes addr 0..31, data=addr, consecutive cycles -> one o_ram_we cycle after last write, addr 0x00, be=0xFFFFFFFF, lane k = k.
REQ-031 Writes 0x40,0x41,0x42 then 0x80 -> write addr 0x02 be=0x00000007; then i_flush -> write addr 0x04 be=0x00000001 with o_flush_done.
REQ-032 i_flush in EMPTY -> o_flush_done next cycle, o_ram_we stays 0.
REQ-033 FILL tag 0x03, then i_we addr 0x0A0 + i_flush same cycle -> write addr 0x03, next cycle write addr 0x05 be=0x00000001 + o_flush_done.
REQ-034 Write addr 5 data 0xAA, then addr 5 data 0xBB, then i_flush -> be=0x00000020, lane 5 = 0xBB, all other lanes 0.
REQ-035 Writes addr 0..9, i_rst one cycle, then i_flush -> no o_ram_we ever, o_flush_done one cycle after flush.

Source files
------------

// File: rtl/ofmap_packer.sv
// ofmap_packer: gathers byte writes from the ppu into 32-byte output RAM
// lines. A line is written out when every lane is filled, when a byte for a
// different line arrives, or on a flush request. Every output is registered,
// so a write appears one cycle after the input event that caused it.
module ofmap_packer #(
  parameter int LINE_BYTES = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [7:0]              i_data,
  input  logic [12:0]             i_addr,
  input  logic                    i_flush,
  output logic                    o_ram_we,
  output logic [7:0]              o_ram_addr,
  output logic [LINE_BYTES*8-1:0] o_ram_data,
  output logic [LINE_BYTES-1:0]   o_ram_be,
  output logic                    o_flush_done
);

  localparam int LANE_W = $clog2(LINE_BYTES);
  localparam int DATA_W = LINE_BYTES * 8;

  // EMPTY: no open line. FILL: one line partially assembled.
  // FLUSH2: an old line went out last cycle, the new one goes out now.
  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_FLUSH2 = 2'd2;

  logic [1:0]            state;
  logic [DATA_W-1:0]     line_buf;
  logic [LINE_BYTES-1:0] line_mask;
  logic [7:0]            line_tag;

  logic [1:0]            nx_state;
  logic [DATA_W-1:0]     nx_buf;
  logic [LINE_BYTES-1:0] nx_mask;
  logic [7:0]            nx_tag;

  logic                  em_we;
  logic [7:0]            em_addr;
  logic [DATA_W-1:0]     em_data;
  logic [LINE_BYTES-1:0] em_be;
  logic                  em_done;

  logic [LANE_W-1:0]     in_lane;
  logic [7:0]            in_tag;
  logic [DATA_W-1:0]     wr_buf;
  logic [LINE_BYTES-1:0] wr_mask;

  assign in_lane = i_addr[LANE_W-1:0];
  assign in_tag  = i_addr[12:LANE_W];

  // Zero every lane whose byte enable is clear, so disabled lanes never
  // carry stale data onto the RAM bus.
  function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0] d,
                                                   input logic [LINE_BYTES-1:0] be);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < LINE_BYTES; k++) begin
      r[k*8 +: 8] = be[k] ? d[k*8 +: 8] : 8'h00;
    end
    return r;
  endfunction

  // Next-state and emit decision: apply the incoming byte first, then the flush.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // skipped one would otherwise infer a latch.
    nx_state = state;
    nx_buf   = line_buf;
    nx_mask  = line_mask;
    nx_tag   = line_tag;
    em_we    = 1'b0;
    em_addr  = '0;
    em_data  = '0;
    em_be    = '0;
    em_done  = 1'b0;
    wr_buf   = '0;
    wr_mask  = '0;

    if (state == ST_FLUSH2) begin
      // Inputs are ignored here; upstream never drives them in this state.
      em_we    = 1'b1;
      em_addr  = line_tag;
      em_data  = mask_lanes(line_buf, line_mask);
      em_be    = line_mask;
      em_done  = 1'b1;
      nx_buf   = '0;
      nx_mask  = '0;
      nx_tag   = '0;
      nx_state = ST_EMPTY;
    end else begin
      if (i_we) begin
        if (state == ST_FILL && in_tag != line_tag) begin
          // Byte for another line: ship the old one, open the new one.
          em_we    = 1'b1;
          em_addr  = line_tag;
          em_data  = mask_lanes(line_buf, line_mask);
          em_be    = line_mask;
          wr_buf[in_lane*8 +: 8] = i_data;
          wr_mask[in_lane]       = 1'b1;
          nx_buf   = wr_buf;
          nx_mask  = wr_mask;
          nx_tag   = in_tag;
          nx_state = ST_FILL;
        end else begin
          // Open a line from EMPTY or add to the current one; a rewrite of
          // a filled lane just overwrites its byte.
          if (state == ST_FILL) begin
            wr_buf  = line_buf;
            wr_mask = line_mask;
          end
          wr_buf[in_lane*8 +: 8] = i_data;
          wr_mask[in_lane]       = 1'b1;
          if (&wr_mask) begin
            em_we    = 1'b1;
            em_addr  = in_tag;
            em_data  = wr_buf;
            em_be    = wr_mask;
            nx_buf   = '0;
            nx_mask  = '0;
            nx_tag   = '0;
            nx_state = ST_EMPTY;
          end else begin
            nx_buf   = wr_buf;
            nx_mask  = wr_mask;
            nx_tag   = in_tag;
            nx_state = ST_FILL;
          end
        end
      end

      if (i_flush) begin
        if (em_we) begin
          // A line is already going out this cycle; a freshly opened line
          // has to wait for FLUSH2, otherwise the flush completes now.
          if (nx_state == ST_FILL) begin
            nx_state = ST_FLUSH2;
          end else begin
            em_done = 1'b1;
          end
        end else if (nx_state == ST_FILL) begin
          em_we    = 1'b1;
          em_addr  = nx_tag;
          em_data  = mask_lanes(nx_buf, nx_mask);
          em_be    = nx_mask;
          em_done  = 1'b1;
          nx_buf   = '0;
          nx_mask  = '0;
          nx_tag   = '0;
          nx_state = ST_EMPTY;
        end else begin
          em_done = 1'b1;
        end
      end
    end
  end

  // State, line buffer and registered outputs; reset overrides any input event.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (i_rst) begin
      state        <= ST_EMPTY;
      line_buf     <= '0;
      line_mask    <= '0;
      line_tag     <= '0;
      o_ram_we     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_data   <= '0;
      o_ram_be     <= '0;
      o_flush_done <= 1'b0;
    end else begin
      state        <= nx_state;
      line_buf     <= nx_buf;
      line_mask    <= nx_mask;
      line_tag     <= nx_tag;
      o_ram_we     <= em_we;
      o_ram_addr   <= em_addr;
      o_ram_data   <= em_data;
      o_ram_be     <= em_be;
      o_flush_done <= em_done;
    end
  end

endmodule

// File: tb/tb_ofmap_packer.sv
// tb_ofmap_packer: table-driven vectors with a scoreboard. Each vector is one
// input cycle; its expected outputs are queued when it is driven and compared
// one cycle later, so every output field is checked on every cycle.
module tb_ofmap_packer;

  logic         clk;
  logic         rst;
  logic         we;
  logic [7:0]   data;
  logic [12:0]  addr;
  logic         flush;
  logic         ram_we;
  logic [7:0]   ram_addr;
  logic [255:0] ram_data;
  logic [31:0]  ram_be;
  logic         flush_done;

  int n_checks = 0;
  int n_errors = 0;

  ofmap_packer #(.LINE_BYTES(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_we         (we),
    .i_data       (data),
    .i_addr       (addr),
    .i_flush      (flush),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_data   (ram_data),
    .o_ram_be     (ram_be),
    .o_flush_done (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         we;
    logic         flush;
    logic [12:0]  addr;
    logic [7:0]   data;
    logic         exp_we;
    logic [7:0]   exp_addr;
    logic [31:0]  exp_be;
    logic         exp_done;
    logic [255:0] exp_data;
  } vec_t;

  typedef struct {
    int           idx;
    logic         we;
    logic [7:0]   addr;
    logic [31:0]  be;
    logic         done;
    logic [255:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic f,
                     input logic [12:0] a, input logic [7:0] d,
                     input logic ew, input logic [7:0] ea, input logic [31:0] ebe,
                     input logic ed, input logic [255:0] edat);
    vec_t v;
    v.rst = r; v.we = w; v.flush = f; v.addr = a; v.data = d;
    v.exp_we = ew; v.exp_addr = ea; v.exp_be = ebe; v.exp_done = ed; v.exp_data = edat;
    vecs.push_back(v);
  endtask

  task automatic idle();
    add(1'b0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
  endtask

  function automatic logic [255:0] lane_val(input int k, input logic [7:0] v);
    return 256'(v) << (8 * k);
  endfunction

  // Compare the current DUT outputs against the oldest queued expectation.
  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check($sformatf("vec%0d ram_we", e.idx),     256'(ram_we),     256'(e.we));
    check($sformatf("vec%0d ram_addr", e.idx),   256'(ram_addr),   256'(e.addr));
    check($sformatf("vec%0d ram_be", e.idx),     256'(ram_be),     256'(e.be));
    check($sformatf("vec%0d ram_data", e.idx),   ram_data,         e.data);
    check($sformatf("vec%0d flush_done", e.idx), 256'(flush_done), 256'(e.done));
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    compare_out();
    rst = v.rst; we = v.we; flush = v.flush; addr = v.addr; data = v.data;
    e.idx = idx; e.we = v.exp_we; e.addr = v.exp_addr; e.be = v.exp_be;
    e.done = v.exp_done; e.data = v.exp_data;
    sb.push_back(e);
  endtask

  initial begin
    logic [255:0] ramp;
    logic [255:0] full7;
    int           waited;
    bit           seen;

    rst = 1'b1; we = 1'b0; flush = 1'b0; addr = '0; data = '0;

    // Reset state.
    add(1'b1, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b1, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);

    // Full line 0, data = address, written out right after the last byte.
    ramp = '0;
    for (int k = 0; k < 32; k++) ramp |= lane_val(k, 8'(k));
    for (int k = 0; k < 32; k++)
      add(1'b0, 1'b1, 1'b0, 13'(k), 8'(k), k == 31, 8'h00,
          (k == 31) ? 32'hFFFF_FFFF : 32'h0, 1'b0, (k == 31) ? ramp : 256'h0);
    idle();

    // Tag change emits the partial line, then flush emits the new one.
    add(1'b0, 1'b1, 1'b0, 13'h040, 8'h11, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b1, 1'b0, 13'h041, 8'h22, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b1, 1'b0, 13'h042, 8'h33, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b1, 1'b0, 13'h080, 8'h44, 1'b1, 8'h02, 32'h7, 1'b0, 256'h332211);
    add(1'b0, 1'b0, 1'b1, 13'h0,   8'h0,  1'b1, 8'h04, 32'h1, 1'b1, 256'h44);
    idle();

    // Flush with nothing buffered: done only.
    add(1'b0, 1'b0, 1'b1, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b1, 256'h0);
    idle();

    // Tag change together with flush: two writes on consecutive cycles.
    add(1'b0, 1'b1, 1'b0, 13'h060, 8'h5A, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b1, 1'b1, 13'h0A0, 8'hC3, 1'b1, 8'h03, 32'h1, 1'b0, 256'h5A);
    add(1'b0, 1'b0, 1'b0, 13'h0,   8'h0,  1'b1, 8'h05, 32'h1, 1'b1, 256'hC3);
    idle();

    // Lane rewrite keeps the latest byte; other lanes stay zero.
    add(1'b0, 1'b1, 1'b0, 13'h005, 8'hAA, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b1, 1'b0, 13'h005, 8'hBB, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b0, 1'b1, 13'h0, 8'h0, 1'b1, 8'h00, 32'h20, 1'b1, lane_val(5, 8'hBB));
    idle();

    // Reset mid-line discards the partial line.
    for (int k = 0; k < 10; k++)
      add(1'b0, 1'b1, 1'b0, 13'(k), 8'(8'hF0 + k), 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b1, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b0, 1'b1, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b1, 256'h0);
    idle();

    // Full-line completion with flush in the same cycle: one write with done.
    full7 = '0;
    for (int k = 0; k < 32; k++) full7 |= lane_val(k, 8'(8'h80 + k));
    for (int k = 0; k < 32; k++)
      add(1'b0, 1'b1, k == 31, 13'(13'h0E0 + k), 8'(8'h80 + k), k == 31, (k == 31) ? 8'h07 : 8'h00,
          (k == 31) ? 32'hFFFF_FFFF : 32'h0, k == 31, (k == 31) ? full7 : 256'h0);
    idle();

    // Tag wrap 0xFF -> 0x00 is an ordinary tag change.
    add(1'b0, 1'b1, 1'b0, 13'h1FE3, 8'h99, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b1, 1'b0, 13'h0004, 8'h66, 1'b1, 8'hFF, 32'h8, 1'b0, lane_val(3, 8'h99));
    add(1'b0, 1'b0, 1'b1, 13'h0, 8'h0, 1'b1, 8'h00, 32'h10, 1'b1, lane_val(4, 8'h66));
    idle();

    // Reset wins over a simultaneous write and flush.
    add(1'b0, 1'b1, 1'b0, 13'h020, 8'h12, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b1, 1'b1, 1'b1, 13'h021, 8'h34, 1'b0, 8'h0, 32'h0, 1'b0, 256'h0);
    add(1'b0, 1'b0, 1'b1, 13'h0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b1, 256'h0);
    idle();

    // Write and flush from EMPTY: single write with done.
    add(1'b0, 1'b1, 1'b1, 13'h1A5, 8'h3C, 1'b1, 8'h0D, 32'h20, 1'b1, lane_val(5, 8'h3C));
    idle();

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    @(negedge clk);
    compare_out();
    check("scoreboard drained", 256'(sb.size()), 256'(0));

    // Hand-written: wait (bounded) for the flush completion of a single byte.
    rst = 1'b0; we = 1'b1; flush = 1'b1; addr = 13'h123; data = 8'h77;
    @(negedge clk);
    we = 1'b0; flush = 1'b0; addr = '0; data = '0;
    waited = 1;
    seen   = flush_done;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      seen = flush_done;
    end
    check("manual flush_done seen", 256'(seen), 256'(1));
    check("manual flush latency", 256'(waited), 256'(1));
    check("manual ram_we", 256'(ram_we), 256'(1));
    check("manual ram_addr", 256'(ram_addr), 256'(8'h09));
    check("manual ram_be", 256'(ram_be), 256'(32'h8));
    check("manual ram_data", ram_data, lane_val(3, 8'h77));
    @(negedge clk);
    check("manual pulse ends we", 256'(ram_we), 256'(0));
    check("manual pulse ends done", 256'(flush_done), 256'(0));
    check("manual idle data", ram_data, 256'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
